// File: rtl/plru_repl_ctrl_pkg.sv
// Shared types and default geometry for the LLC pseudo-LRU replacement controller.
// Widths here follow the default LLC line geometry; the modules re-derive widths from their own parameters.
package plru_repl_ctrl_pkg;

    localparam int LINE_N_WAY = 16;
    localparam int LINE_N_SET = 16384;

    localparam int WAY_W  = $clog2(LINE_N_WAY);
    localparam int N_NODE = LINE_N_WAY - 1;

    typedef logic [LINE_N_WAY-2:0] plru_state_t;

    typedef enum logic [1:0] {
        OP_TOUCH     = 2'b00,
        OP_VICTIM    = 2'b01,
        OP_PEEK      = 2'b10,
        OP_CLEAR_SET = 2'b11
    } plru_op_e;

    // FOLLOW/TOUCH descend along a known target bit; SEEK/EVICT descend away from the node bit.
    typedef enum logic [1:0] {
        STEP_FOLLOW,
        STEP_TOUCH,
        STEP_SEEK,
        STEP_EVICT
    } step_mode_e;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_WALK,
        ST_STORE,
        ST_RESP
    } fsm_state_e;

endpackage

// File: rtl/plru_repl_ctrl_if.sv
// Request/response bus between the cache controller (master) and the replacement controller (slave).
interface plru_if
    import plru_repl_ctrl_pkg::*;
#(
    parameter int N_WAY = LINE_N_WAY,
    parameter int N_SET = LINE_N_SET
) ();

    localparam int L     = $clog2(N_WAY);
    localparam int SET_W = $clog2(N_SET);

    logic             req_valid;
    logic             req_ready;
    plru_op_e         req_op;
    logic [SET_W-1:0] req_set;
    logic [L-1:0]     req_way;
    logic [N_WAY-1:0] req_inv_mask;
    logic             resp_valid;
    logic             resp_ready;
    logic [L-1:0]     resp_way;
    logic             resp_from_invalid;
    logic             init_done;

    modport master (
        output req_valid, req_op, req_set, req_way, req_inv_mask, resp_ready,
        input  req_ready, resp_valid, resp_way, resp_from_invalid, init_done
    );

    modport slave (
        input  req_valid, req_op, req_set, req_way, req_inv_mask, resp_ready,
        output req_ready, resp_valid, resp_way, resp_from_invalid, init_done
    );

endinterface

// File: rtl/plru_repl_ctrl_tree_step.sv
// One level of the PLRU tree walk: picks the branch, optionally records it in the node,
// and returns the child node index.
module plru_tree_step
    import plru_repl_ctrl_pkg::*;
#(
    parameter int N_WAY = LINE_N_WAY
) (
    input  logic [$clog2(N_WAY)-1:0] node_i,
    input  logic [N_WAY-2:0]         bits_i,
    input  logic                     tgt_bit_i,
    input  step_mode_e               mode_i,
    output logic [$clog2(N_WAY)-1:0] next_node_o,
    output logic                     victim_bit_o,
    output logic [N_WAY-2:0]         bits_o
);

    localparam int L = $clog2(N_WAY);

    logic         dir;
    logic [L:0]   next_wide;

    always_comb begin
        victim_bit_o = ~bits_i[node_i];
        dir          = (mode_i == STEP_SEEK || mode_i == STEP_EVICT) ? victim_bit_o : tgt_bit_i;
        bits_o       = bits_i;
        if (mode_i == STEP_TOUCH || mode_i == STEP_EVICT) begin
            bits_o[node_i] = dir;
        end
        // Past the leaf level the child index overflows; the caller never uses it there.
        next_wide   = ((L+1)'(node_i) << 1) + (L+1)'(1) + (L+1)'(dir);
        next_node_o = next_wide[L-1:0];
    end

endmodule

// File: rtl/plru_repl_ctrl.sv
// Pseudo-LRU replacement controller: owns the per-set tree bits and serves one
// TOUCH/VICTIM/PEEK/CLEAR_SET request at a time with a read-modify-write walk.
module plru_repl_ctrl
    import plru_repl_ctrl_pkg::*;
#(
    parameter int N_WAY = LINE_N_WAY,
    parameter int N_SET = LINE_N_SET
) (
    input logic clk,
    input logic rst,
    plru_if.slave bus
);

    // state | meaning
    // INIT  | clearing one set per cycle after reset
    // IDLE  | waiting for a request (req_ready high)
    // LOAD  | fetch set bits, resolve invalid-way or touch target
    // WALK  | one tree level per cycle, L cycles
    // STORE | write working bits back to the array
    // RESP  | hold the response until resp_ready

    localparam int L     = $clog2(N_WAY);
    localparam int SET_W = $clog2(N_SET);
    localparam int LVL_W = (L > 1) ? $clog2(L) : 1;

    logic [N_WAY-2:0] mem_q [N_SET];

    fsm_state_e       state_q;
    plru_op_e         op_q;
    logic [SET_W-1:0] set_q;
    logic [SET_W-1:0] sweep_q;
    logic [L-1:0]     way_q;
    logic [L-1:0]     node_q;
    logic [N_WAY-1:0] mask_q;
    logic [N_WAY-2:0] bits_q;
    logic [LVL_W-1:0] lvl_q;
    logic             tgt_known_q;
    logic             from_inv_q;
    logic             req_ready_q;
    logic             resp_valid_q;
    logic [L-1:0]     resp_way_q;
    logic             resp_inv_q;
    logic             init_done_q;

    logic [L-1:0]     low_idx_d;
    logic [LVL_W-1:0] bit_idx_d;
    step_mode_e       mode_d;
    logic [L-1:0]     step_node_d;
    logic             step_victim_d;
    logic [N_WAY-2:0] step_bits_d;

    always_comb begin
        low_idx_d = '0;
        for (int i = N_WAY - 1; i >= 0; i--) begin
            if (mask_q[i]) low_idx_d = L'(i);
        end
        bit_idx_d = LVL_W'(L - 1) - lvl_q;
        case ({tgt_known_q, op_q != OP_PEEK})
            2'b11:   mode_d = STEP_TOUCH;
            2'b10:   mode_d = STEP_FOLLOW;
            2'b01:   mode_d = STEP_EVICT;
            default: mode_d = STEP_SEEK;
        endcase
    end

    plru_tree_step #(.N_WAY(N_WAY)) u_step (
        .node_i       (node_q),
        .bits_i       (bits_q),
        .tgt_bit_i    (way_q[bit_idx_d]),
        .mode_i       (mode_d),
        .next_node_o  (step_node_d),
        .victim_bit_o (step_victim_d),
        .bits_o       (step_bits_d)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_INIT) begin
                mem_q[sweep_q] <= '0;
            end else if (state_q == ST_STORE) begin
                mem_q[set_q] <= bits_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_INIT;
            sweep_q      <= '0;
            op_q         <= OP_TOUCH;
            set_q        <= '0;
            way_q        <= '0;
            node_q       <= '0;
            mask_q       <= '0;
            bits_q       <= '0;
            lvl_q        <= '0;
            tgt_known_q  <= 1'b0;
            from_inv_q   <= 1'b0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_way_q   <= '0;
            resp_inv_q   <= 1'b0;
            init_done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    sweep_q <= sweep_q + 1'b1;
                    if (sweep_q == SET_W'(N_SET - 1)) begin
                        state_q     <= ST_IDLE;
                        req_ready_q <= 1'b1;
                        init_done_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        op_q        <= bus.req_op;
                        set_q       <= bus.req_set;
                        way_q       <= bus.req_way;
                        mask_q      <= bus.req_inv_mask;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    bits_q      <= mem_q[set_q];
                    node_q      <= '0;
                    lvl_q       <= '0;
                    tgt_known_q <= 1'b1;
                    from_inv_q  <= 1'b0;
                    state_q     <= ST_WALK;
                    case (op_q)
                        OP_CLEAR_SET: begin
                            bits_q  <= '0;
                            way_q   <= '0;
                            state_q <= ST_STORE;
                        end
                        OP_TOUCH: ;
                        default: begin
                            if (|mask_q) begin
                                way_q      <= low_idx_d;
                                from_inv_q <= 1'b1;
                            end else begin
                                way_q       <= '0;
                                tgt_known_q <= 1'b0;
                            end
                        end
                    endcase
                end
                ST_WALK: begin
                    bits_q <= step_bits_d;
                    node_q <= step_node_d;
                    if (!tgt_known_q) way_q[bit_idx_d] <= step_victim_d;
                    lvl_q <= lvl_q + 1'b1;
                    if (lvl_q == LVL_W'(L - 1)) state_q <= ST_STORE;
                end
                ST_STORE: begin
                    state_q      <= ST_RESP;
                    resp_valid_q <= 1'b1;
                    resp_way_q   <= way_q;
                    resp_inv_q   <= from_inv_q;
                end
                ST_RESP: begin
                    if (bus.resp_ready) begin
                        resp_valid_q <= 1'b0;
                        req_ready_q  <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    // Outputs read as zero during the reset cycle itself, before the flops have seen the edge.
    assign bus.req_ready         = req_ready_q & ~rst;
    assign bus.resp_valid        = resp_valid_q & ~rst;
    assign bus.resp_way          = rst ? '0 : resp_way_q;
    assign bus.resp_from_invalid = resp_inv_q & ~rst;
    assign bus.init_done         = init_done_q & ~rst;

endmodule

// File: tb/tb_plru_repl_ctrl.sv
// Scoreboard bench for plru_repl_ctrl: directed requests push expected responses,
// an independent monitor pops and compares way, invalid flag and latency.
module tb_plru_repl_ctrl;
    import plru_repl_ctrl_pkg::*;

    localparam int NW = 16;
    localparam int NS = 16384;
    localparam int L  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    plru_if #(.N_WAY(NW), .N_SET(NS)) bus ();

    plru_repl_ctrl #(.N_WAY(NW), .N_SET(NS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int way;
        int inv;
        int lat;
        int acc;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Monitor: latency counts from the accepting edge to the first cycle resp_valid is seen.
    int  first_cyc = 0;
    bit  seen      = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.resp_valid) begin
            if (!seen) begin
                seen      = 1'b1;
                first_cyc = cyc;
            end
            if (bus.resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_resp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("resp_way", bus.resp_way, e.way);
                    chk("resp_from_invalid", bus.resp_from_invalid, e.inv);
                    chk("resp_latency", first_cyc - e.acc, e.lat);
                end
                seen = 1'b0;
            end
        end
        if (rst) seen = 1'b0;
    end

    task automatic issue(input plru_op_e op, input int set, input int way,
                         input logic [NW-1:0] mask, input int ew, input int einv);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("req_ready_timeout", 0, 1);
            return;
        end
        bus.req_valid    = 1'b1;
        bus.req_op       = op;
        bus.req_set      = 14'(set);
        bus.req_way      = 4'(way);
        bus.req_inv_mask = mask;
        e.way = ew;
        e.inv = einv;
        e.lat = (op == OP_CLEAR_SET) ? 2 : L + 2;
        e.acc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.resp_valid) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) chk("drain_timeout", 0, 1);
    endtask

    // Releases rst at the current negedge and counts edges until init_done.
    task automatic wait_init();
        int n;
        int bad;
        bad = 0;
        rst = 1'b0;
        @(negedge clk);
        n = 1;
        chk("post_rst_req_ready", bus.req_ready, 0);
        chk("post_rst_resp_valid", bus.resp_valid, 0);
        chk("post_rst_init_done", bus.init_done, 0);
        while (!bus.init_done && n < NS + 50) begin
            if (bus.resp_valid) bad++;
            @(negedge clk);
            n++;
        end
        chk("init_edges", n, NS);
        chk("resp_during_init", bad, 0);
        chk("idle_req_ready", bus.req_ready, 1);
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.req_op       = OP_TOUCH;
        bus.req_set      = '0;
        bus.req_way      = '0;
        bus.req_inv_mask = '0;
        bus.resp_ready   = 1'b1;
        rst              = 1'b1;

        @(negedge clk);
        @(negedge clk);
        chk("rst_req_ready", bus.req_ready, 0);
        chk("rst_resp_valid", bus.resp_valid, 0);
        chk("rst_init_done", bus.init_done, 0);
        wait_init();

        issue(OP_VICTIM, 5, 0, 16'h0000, 15, 0);
        issue(OP_VICTIM, 5, 0, 16'h0000, 7, 0);
        issue(OP_TOUCH, 0, 3, 16'h0000, 3, 0);
        issue(OP_PEEK, 0, 0, 16'h0000, 15, 0);
        issue(OP_PEEK, 0, 0, 16'h0000, 15, 0);
        issue(OP_VICTIM, 9, 0, 16'h0A00, 9, 1);
        issue(OP_PEEK, 9, 0, 16'h0000, 7, 0);
        issue(OP_VICTIM, 11, 0, 16'hFFFF, 0, 1);
        issue(OP_VICTIM, 12, 0, 16'h8000, 15, 1);
        issue(OP_PEEK, 12, 0, 16'h0000, 7, 0);
        issue(OP_TOUCH, 30, 8, 16'h0000, 8, 0);
        issue(OP_VICTIM, 30, 0, 16'h0000, 7, 0);
        issue(OP_CLEAR_SET, 30, 0, 16'h0000, 0, 0);
        issue(OP_PEEK, 30, 0, 16'h0000, 15, 0);
        drain();

        // Back-pressure: response must hold while a stray request is ignored.
        bus.resp_ready = 1'b0;
        issue(OP_VICTIM, 20, 0, 16'h0000, 15, 0);
        begin
            int n;
            n = 0;
            while (!bus.resp_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
            chk("stall_resp_seen", bus.resp_valid, 1);
        end
        for (int i = 0; i < 3; i++) begin
            chk("stall_resp_valid", bus.resp_valid, 1);
            chk("stall_resp_way", bus.resp_way, 15);
            chk("stall_req_ready", bus.req_ready, 0);
            bus.req_valid    = (i == 0);
            bus.req_op       = OP_TOUCH;
            bus.req_set      = 14'd7;
            bus.req_way      = 4'd15;
            bus.req_inv_mask = '0;
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1 bus.resp_ready = 1'b1;
        drain();
        issue(OP_PEEK, 7, 0, 16'h0000, 15, 0);
        drain();

        // Reset in the second WALK cycle drops the request and reruns INIT.
        begin
            int n;
            n = 0;
            while (!bus.req_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        bus.req_valid    = 1'b1;
        bus.req_op       = OP_VICTIM;
        bus.req_set      = 14'd5;
        bus.req_inv_mask = '0;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midwalk_rst_resp_valid", bus.resp_valid, 0);
        chk("midwalk_rst_init_done", bus.init_done, 0);
        chk("midwalk_rst_req_ready", bus.req_ready, 0);
        @(negedge clk);
        wait_init();

        issue(OP_VICTIM, 5, 0, 16'h0000, 15, 0);
        issue(OP_CLEAR_SET, 5, 0, 16'h0000, 0, 0);
        issue(OP_VICTIM, 5, 0, 16'h0000, 15, 0);
        drain();

        repeat (5) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
